pc_sched: RTL and testbench

PC_SCHED -- requirements
Module: pc_sched

---
 rtl/pc_sched.sv | 72 +++++++
 tb/tb_pc_sched.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pc_sched.sv
// pc_sched: PC/IF_ID scheduling with redirect, load-use stall, exception and interrupt trap control.
// Define PC_SCHED_IRQ_EDGE_EN for rising-edge irq detection; level-sensitive otherwise.
module pc_sched #(
  parameter int STALL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       branch_taken,
  input  logic       jump,
  input  logic       jr,
  input  logic       load_use,
  input  logic       irq,
  input  logic       exception,
  input  logic       eret,
  output logic       PC_IF_ID_Write,
  output logic [2:0] select_PC_next,
  output logic [1:0] status,
  output logic       kernel,
  output logic       irq_pending,
  output logic [7:0] trap_count
);
  typedef enum logic {RUN, STALL} state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       kernel_q, kernel_d, pend_q, pend_d;
  logic [7:0] trap_q, trap_d;
  logic       irq_evt, run, redirect, take, trap, stall_go;
`ifdef PC_SCHED_IRQ_EDGE_EN
  logic irq_d1_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq_d1_q <= 1'b0;
    else        irq_d1_q <= irq;
  assign irq_evt = irq & ~irq_d1_q;
`else
  assign irq_evt = irq;
`endif
  always_comb begin
    run            = state_q == RUN;
    redirect       = branch_taken | jump | jr;
    take           = run & pend_q & ~kernel_q & ~exception & ~redirect;
    trap           = exception | take;
    stall_go       = run & ~trap & ~redirect & load_use & (STALL_CYCLES > 1);
    PC_IF_ID_Write = ~rst_n | exception | (run & (take | redirect | ~load_use));
    select_PC_next = (~rst_n | ~run | trap) ? 3'b000 :
                     branch_taken ? 3'b100 : jump ? 3'b010 : jr ? 3'b001 : 3'b000;
    status         = rst_n ? {take, exception} : 2'b00;
    state_d        = exception ? RUN : stall_go ? STALL : (!run && cnt_q == 3'd0) ? RUN : state_q;
    cnt_d          = exception ? 3'd0 : stall_go ? 3'(STALL_CYCLES - 2) :
                     (!run && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    // eret only travels with jr, so it is honoured exactly when that redirect is
    kernel_d       = trap | (kernel_q & ~(run & eret));
    pend_d         = irq_evt | (pend_q & ~take);
    trap_d         = (trap && trap_q != 8'hff) ? trap_q + 8'd1 : trap_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      kernel_q <= 1'b0;
      pend_q   <= 1'b0;
      trap_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kernel_q <= kernel_d;
      pend_q   <= pend_d;
      trap_q   <= trap_d;
    end
  assign kernel      = kernel_q;
  assign irq_pending = pend_q;
  assign trap_count  = trap_q;
endmodule

// File: tb/tb_pc_sched.sv
// tb_pc_sched: randomized and directed checks of pc_sched against a cycle-level behavioural model.
module tb_pc_sched;
  localparam int SC = 3;
  logic       clk, rst_n, branch_taken, jump, jr, load_use, irq, exception, eret;
  logic       PC_IF_ID_Write, kernel, irq_pending;
  logic [2:0] select_PC_next;
  logic [1:0] status;
  logic [7:0] trap_count;
  int  n_cmp, n_bad;
  int  m_left, m_traps;
  bit  m_kernel, m_pend, m_prev;

  pc_sched #(.STALL_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .jump(jump), .jr(jr),
    .load_use(load_use), .irq(irq), .exception(exception), .eret(eret),
    .PC_IF_ID_Write(PC_IF_ID_Write), .select_PC_next(select_PC_next), .status(status),
    .kernel(kernel), .irq_pending(irq_pending), .trap_count(trap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_traps = 0; m_kernel = 0; m_pend = 0; m_prev = 0;
  endtask

  task automatic step(input bit bt, input bit j, input bit r, input bit lu,
                      input bit ir, input bit ex, input bit er);
    int e_wr, e_sel, e_st;
    bit redir, ev;
    @(negedge clk);
    branch_taken = bt; jump = j; jr = r; load_use = lu; irq = ir; exception = ex; eret = er;
    #1;
    redir = bt | j | r;
    e_wr = 1; e_sel = 0; e_st = 0;
    chk("kernel", kernel, m_kernel);
    chk("irq_pending", irq_pending, m_pend);
    chk("trap_count", trap_count, m_traps);
    if (ex) begin
      e_st = 1; m_kernel = 1; m_traps = (m_traps < 255) ? m_traps + 1 : 255; m_left = 0;
    end else if (m_left > 0) begin
      e_wr = 0; m_left--;
    end else if (m_pend && !m_kernel && !redir) begin
      e_st = 2; m_pend = 0; m_kernel = 1; m_traps = (m_traps < 255) ? m_traps + 1 : 255;
    end else if (redir) begin
      e_sel = bt ? 4 : j ? 2 : 1;
      if (er) m_kernel = 0;
    end else if (lu) begin
      e_wr = 0; m_left = SC - 1;
    end
`ifdef PC_SCHED_IRQ_EDGE_EN
    ev = ir & ~m_prev;
`else
    ev = ir;
`endif
    if (ev) m_pend = 1;
    m_prev = ir;
    chk("wr", PC_IF_ID_Write, e_wr);
    chk("sel", select_PC_next, e_sel);
    chk("status", status, e_st);
  endtask

  task automatic rst_chk();
    @(negedge clk);
    rst_n = 1'b0;
    {branch_taken, jump, jr, load_use, irq, exception, eret} = 7'($urandom);
    #1;
    chk("rst_wr", PC_IF_ID_Write, 1);
    chk("rst_sel", select_PC_next, 0);
    chk("rst_status", status, 0);
    chk("rst_kernel", kernel, 0);
    chk("rst_pend", irq_pending, 0);
    chk("rst_traps", trap_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    {branch_taken, jump, jr, load_use, irq, exception, eret} = 7'd0;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    {branch_taken, jump, jr, load_use, irq, exception, eret} = 7'd0;
    rst_chk();
    // load-use stall, then redirect priority
    step(0,0,0,1,0,0,0); repeat (4) step(0,0,0,0,0,0,0);
    step(1,1,0,1,0,0,0);
    // irq blocked by jump, taken on next idle cycle
    step(0,1,0,0,1,0,0); step(0,0,0,0,0,0,0); step(0,0,0,0,0,0,0);
    // in kernel an irq waits for jr+eret
    step(0,0,0,0,1,0,0); repeat (3) step(0,0,0,0,0,0,0);
    step(0,0,1,0,0,0,1); step(0,0,0,0,0,0,0); step(0,0,1,0,0,0,1);
    // exception on second stall cycle, nested exception
    step(0,0,0,1,0,0,0); step(0,0,0,0,0,1,0); step(0,0,0,0,0,0,0); step(0,0,0,0,0,1,0);
    step(0,0,1,0,0,0,1);
    // irq held high, then leave kernel while still high
    repeat (4) step(0,0,0,0,1,0,0);
    step(0,0,1,0,1,0,1); step(0,0,0,0,1,0,0); step(0,0,0,0,0,0,0);
    step(0,0,1,0,0,0,1); step(0,0,0,0,0,0,0);
    // reset in the middle of a stall
    step(0,0,0,1,0,0,0);
    rst_chk();
    for (int i = 0; i < 4000; i++) begin
      bit r;
      r = ($urandom_range(7) == 0);
      step($urandom_range(7) == 0, $urandom_range(7) == 0, r, $urandom_range(4) == 0,
           $urandom_range(5) == 0, $urandom_range(11) == 0, r & 1'($urandom_range(1)));
      if (i == 2500) rst_chk();
    end
    repeat (1500) step(0,0,0,0,0,1,0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
